// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared defaults, state encoding and helpers for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam int PC_BITS_DEFAULT     = 8;
  localparam int MEM_DEPTH_DEFAULT   = 24;
  localparam int STACK_DEPTH_DEFAULT = 4;

  // Encoding is visible on o_state, so values are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_HALT  = 3'd2,
    ST_FAULT = 3'd3
  } pc_state_t;

  // Index width for an array of n entries (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : pc_ret_stack
// Description : LIFO return-address stack with push/pop/flush and
//               full/empty flags. The top entry is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_BITS_DEFAULT,
  parameter int DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int                 SP_BITS  = $clog2(DEPTH + 1);
  localparam int                 IDX_BITS = idx_bits(DEPTH);
  localparam logic [SP_BITS-1:0] SP_FULL  = SP_BITS'(DEPTH);

  logic [SP_BITS-1:0]  sp;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [IDX_BITS-1:0] wr_idx;
  logic [IDX_BITS-1:0] rd_idx;
  logic                do_push;
  logic                do_pop;

  assign full    = (sp == SP_FULL);
  assign empty   = (sp == '0);
  assign wr_idx  = IDX_BITS'(sp);
  assign rd_idx  = IDX_BITS'(sp - SP_BITS'(1));
  assign top     = mem[rd_idx];
  // Overflow/underflow are refused here as well as in the caller.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Stack pointer: flush empties the stack, push/pop move it by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (flush) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SP_BITS'(1);
    end else if (do_pop) begin
      sp <= sp - SP_BITS'(1);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with IDLE/RUN/HALT/FAULT control,
//               stall, branch, call/return and range checking of targets.
//               Optional macro PC_CALL_STACK_EN adds a return stack
//               (pc_ret_stack); without it, call acts as branch and ret is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_BITS     = PC_BITS_DEFAULT,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT,
  parameter int STACK_DEPTH = STACK_DEPTH_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_run,
  input  logic               i_halt,
  input  logic               i_clear,
  input  logic               i_stall,
  input  logic               i_branch,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic [PC_BITS-1:0] i_target,
  output logic [PC_BITS-1:0] o_pc,
  output logic               o_fetch_valid,
  output logic [2:0]         o_state,
  output logic               o_fault
);

  localparam logic [PC_BITS-1:0] LAST_ADDR = PC_BITS'(MEM_DEPTH - 1);

  pc_state_t          state;
  pc_state_t          state_nxt;
  logic [PC_BITS-1:0] pc;
  logic [PC_BITS-1:0] pc_nxt;
  logic [PC_BITS-1:0] pc_inc;
  logic               fault;
  logic               fault_nxt;
  logic               target_bad;
  logic               jump_req;

  // Sequential successor of the current PC, wrapping at the last address.
  assign pc_inc     = (pc == LAST_ADDR) ? '0 : pc + PC_BITS'(1);
  assign target_bad = (i_target > LAST_ADDR);

`ifdef PC_CALL_STACK_EN
  logic               push;
  logic               pop;
  logic               flush;
  logic [PC_BITS-1:0] stk_top;
  logic               stk_full;
  logic               stk_empty;

  // Call is handled separately because it also pushes.
  assign jump_req = i_branch;

  pc_ret_stack #(
    .WIDTH (PC_BITS),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (i_clk),
    .rst_n     (i_nrst),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );
`else
  // No stack: call degenerates to a plain branch and ret has no effect.
  assign jump_req = i_branch | i_call;

  logic     unused_ret;
  localparam int unused_stack_depth = STACK_DEPTH;
  assign unused_ret = i_ret;
`endif

  // State, PC and sticky fault registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state <= ST_IDLE;
      pc    <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      fault <= fault_nxt;
    end
  end

  // Next-state logic with the fixed per-cycle request priority in RUN.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_nxt = fault;
`ifdef PC_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (i_run) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          state_nxt = ST_HALT;
        end else if (!i_run) begin
          state_nxt = ST_IDLE;
        end else if (i_stall) begin
          pc_nxt = pc;
`ifdef PC_CALL_STACK_EN
        end else if (i_ret) begin
          if (stk_empty) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = stk_top;
          end
        end else if (i_call) begin
          if (target_bad || stk_full) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = i_target;
          end
`endif
        end else if (jump_req) begin
          if (target_bad) begin
            state_nxt = ST_FAULT;
            fault_nxt = 1'b1;
          end else begin
            pc_nxt = i_target;
          end
        end else begin
          pc_nxt = pc_inc;
        end
      end
      ST_HALT, ST_FAULT: begin
        if (i_clear) begin
          state_nxt = ST_IDLE;
          pc_nxt    = '0;
          fault_nxt = 1'b0;
`ifdef PC_CALL_STACK_EN
          flush     = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_pc          = pc;
  assign o_state       = state;
  assign o_fault       = fault;
  assign o_fetch_valid = (state == ST_RUN);

endmodule
`default_nettype wire
